// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator command path.
// Holds the decoded command struct carried from decoder to dispatcher to
// the unit broadcast bus, the dispatcher FSM state type and small helpers.
package accel_pkg;

  localparam int unsigned UNIT_COUNT          = 256;
  localparam int unsigned STALL_LIMIT_DEFAULT = 1024;
  localparam int unsigned UNIT_ID_W           = 8;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned SIZE_W              = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_STORE   = 3'd2,
    OP_COPY    = 3'd3,
    OP_ADD_VEC = 3'd4,
    OP_MUL_VEC = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    COMP_INT  = 2'd0,
    COMP_FP16 = 2'd1,
    COMP_FP32 = 2'd2,
    COMP_BF16 = 2'd3
  } comp_e;

  typedef struct packed {
    logic [UNIT_ID_W-1:0] unit_id;
    logic [UNIT_ID_W-1:0] src_unit_id;
    op_e                  op_code;
    comp_e                comp_type;
    logic [ADDR_W-1:0]    addr;
    logic                 valid;
    logic [SIZE_W-1:0]    size;
  } decoded_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAZARD = 2'd1,
    ISSUE  = 2'd2
  } disp_state_e;

  // Ops that read a second unit's result and so must wait on it too.
  function automatic logic reads_src(input op_e op);
    return (op == OP_COPY) || (op == OP_ADD_VEC);
  endfunction

  function automatic logic id_in_range(input logic [UNIT_ID_W-1:0] id, input int unsigned n);
    return 32'(id) < n;
  endfunction

endpackage

// File: rtl/accel_scoreboard.sv
// Per-unit busy scoreboard with a running busy count.
//   clk_i, rst_ni    clock, async active-low reset
//   flush_i          synchronous clear of all bits and the count
//   set_i/set_id_i   mark one unit busy (wins over a same-cycle clear)
//   clr_i            completion pulses, one bit per unit
//   chk_a/b_id_i     ids to test; busy_a/b_o see same-cycle clears (bypass)
//   cnt_o            registered popcount of the scoreboard
module accel_scoreboard
  import accel_pkg::*;
#(
  parameter int unsigned NumUnits = UNIT_COUNT,
  parameter int unsigned CntW     = $clog2(NumUnits) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 set_i,
  input  logic [UNIT_ID_W-1:0] set_id_i,
  input  logic [NumUnits-1:0]  clr_i,
  input  logic [UNIT_ID_W-1:0] chk_a_id_i,
  input  logic [UNIT_ID_W-1:0] chk_b_id_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic [CntW-1:0]      cnt_o
);

  localparam int unsigned IdxW = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  logic [NumUnits-1:0] sb_q, sb_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumUnits-1:0] set_mask;
  logic [NumUnits-1:0] clr_eff;
  logic [CntW-1:0]     n_clr;
  logic                set_inc;

  always_comb begin
    set_mask = '0;
    if (set_i && id_in_range(set_id_i, NumUnits)) begin
      set_mask[set_id_i[IdxW-1:0]] = 1'b1;
    end
    // Done on an idle unit is ignored; a same-cycle set overrides the clear.
    clr_eff = clr_i & sb_q & ~set_mask;
    set_inc = |(set_mask & ~sb_q);
    n_clr   = '0;
    for (int i = 0; i < int'(NumUnits); i++) begin
      n_clr = n_clr + CntW'(clr_eff[i]);
    end
    sb_d  = (sb_q & ~clr_i) | set_mask;
    cnt_d = cnt_q + CntW'(set_inc) - n_clr;
    if (flush_i) begin
      sb_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy_a_o = id_in_range(chk_a_id_i, NumUnits) && sb_q[chk_a_id_i[IdxW-1:0]]
               && !clr_i[chk_a_id_i[IdxW-1:0]];
    busy_b_o = id_in_range(chk_b_id_i, NumUnits) && sb_q[chk_b_id_i[IdxW-1:0]]
               && !clr_i[chk_b_id_i[IdxW-1:0]];
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/accel_dispatcher.sv
// Command dispatcher: holds one decoded command, waits until its destination
// (and, for COPY/ADD_VEC, its source) unit is free, then broadcasts it.
//   cmd_valid/cmd_ready/cmd_ctrl   decoded command input
//   iss_valid/iss_ready/iss_ctrl   issue bus output
//   unit_done                      per-unit completion pulses
//   flush                          synchronous abort of all state
//   idle, busy_cnt, stall_err      status
module accel_dispatcher
  import accel_pkg::*;
#(
  parameter int unsigned NUM_UNITS   = UNIT_COUNT,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT,
  localparam int unsigned CntW       = $clog2(NUM_UNITS) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  decoded_ctrl_t        cmd_ctrl,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output decoded_ctrl_t        iss_ctrl,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 flush,
  output logic                 idle,
  output logic [CntW-1:0]      busy_cnt,
  output logic                 stall_err
);

  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  disp_state_e       state_q, state_d;
  decoded_ctrl_t     cmd_q, cmd_d;
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;

  logic sb_set;
  logic busy_dst, busy_src;
  logic uses_src;
  logic ids_ok;
  logic hazard;

  accel_scoreboard #(
    .NumUnits (NUM_UNITS),
    .CntW     (CntW)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .set_i      (sb_set),
    .set_id_i   (cmd_q.unit_id),
    .clr_i      (unit_done),
    .chk_a_id_i (cmd_q.unit_id),
    .chk_b_id_i (cmd_q.src_unit_id),
    .busy_a_o   (busy_dst),
    .busy_b_o   (busy_src),
    .cnt_o      (busy_cnt)
  );

  always_comb begin
    uses_src = reads_src(cmd_q.op_code);
    // The source id only matters for ops that actually read it.
    ids_ok   = id_in_range(cmd_q.unit_id, NUM_UNITS) &&
               (!uses_src || id_in_range(cmd_q.src_unit_id, NUM_UNITS));
    hazard   = busy_dst || (uses_src && busy_src);
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;
    sb_set      = 1'b0;
    cmd_ready   = (state_q == IDLE);
    iss_valid   = (state_q == ISSUE);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ctrl.valid && (cmd_ctrl.op_code != OP_NOP)) begin
          cmd_d   = cmd_ctrl;
          state_d = HAZARD;
        end
      end
      HAZARD: begin
        if (!ids_ok) begin
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else if (hazard) begin
          if (stall_cnt_q != StallW'(STALL_LIMIT)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
          if (stall_cnt_d == StallW'(STALL_LIMIT)) begin
            stall_err_d = 1'b1;
          end
        end else begin
          state_d     = ISSUE;
          stall_cnt_d = '0;
        end
      end
      ISSUE: begin
        if (iss_ready) begin
          sb_set  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      cmd_d       = '0;
      stall_cnt_d = '0;
      stall_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign iss_ctrl  = cmd_q;
  assign stall_err = stall_err_q;
  assign idle      = (state_q == IDLE) && (busy_cnt == '0);

endmodule
